sdram_burst_sched: RTL
======================

# sdram_burst_sched

Burst scheduler that sits between a pixel-rate write source FIFO, a read sink FIFO and the single-port full-page SDRAM controller. Uses an SDRAM region as a large circular FIFO: it issues 256-word write bursts when the source has a full burst buffered and 256-word read bursts when the sink has room, arbitrating between the two and generating page-aligned addresses. It tracks how many bursts are stored, so reads never overtake writes and writes never overrun unread data.

## Interface
- BURST_LEN, 256: words per burst; must equal the controller page length.
- BASE_ADDR, 22'd0: first word address of the region; multiple of BURST_LEN.
- DEPTH_BURSTS, 16384: region size in bursts; at least 2.
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  allows new bursts to start; never aborts a burst in progress.
- src_level  in  10  words held in the source FIFO (show-ahead).
- src_rd  out  1  source FIFO read strobe.
- src_data  in  16  source FIFO head word.
- snk_free  in  10  free words in the sink FIFO.
- snk_wr  out  1  sink FIFO write strobe.
- snk_data  out  16  sink FIFO write data.
- wr_req  out  1  write burst request to the controller.
- waddr  out  22  write burst start address {bank,row,col}.
- wdata  out  16  write data to the controller; equals src_data.
- wr_ack  in  1  one-cycle pulse; controller takes wdata this cycle and the next BURST_LEN-1 cycles.
- rd_req  out  1  read burst request.
- raddr  out  22  read burst start address.
- rd_ack  in  1  one-cycle read accept pulse.
- rdata  in  16  read data.
- rdata_vld  in  1  read data valid, BURST_LEN beats per burst.
- occ  out  15  bursts stored and not yet read.
- busy  out  1  high in every state except IDLE.

## Operation
- The FSM has five states: IDLE, WR_REQ, WR_DATA, RD_REQ and RD_DATA. Only one burst is outstanding at a time.
- wr_ready = enable && src_level >= BURST_LEN && occ < DEPTH_BURSTS.
- rd_ready = enable && snk_free >= BURST_LEN && occ != 0.
- IDLE transitions:
  - Only wr_ready -> WR_REQ.
  - Only rd_ready -> RD_REQ.
  - Both ready: the arbitration rule is set under Configuration.
- WR_REQ: wr_req=1 until wr_ack is sampled. On the wr_ack cycle, wr_req drops next cycle, src_rd=1, beat_cnt=1, then -> WR_DATA.
- WR_DATA: src_rd=1 until the beat count reaches BURST_LEN. After the final beat:
  - -> IDLE.
  - occ+1.
  - The write index advances.
- RD_REQ: rd_req=1 until rd_ack is sampled, then -> RD_DATA.
- RD_DATA: each rdata_vld beat is counted. On the BURST_LEN-th beat:
  - -> IDLE.
  - occ-1.
  - The read index advances.
- Sink path: snk_wr and snk_data are rdata_vld and rdata registered by one cycle. snk_wr is gated to RD_REQ/RD_DATA; rdata_vld in any other state is ignored.
- Addressing:
  - waddr = BASE_ADDR + wr_idx*BURST_LEN and raddr = BASE_ADDR + rd_idx*BURST_LEN.
  - Both addresses are registered and change only at burst end, so they are stable for the whole burst.
  - Each index wraps from DEPTH_BURSTS-1 to 0.
- Full region (occ == DEPTH_BURSTS): writes are blocked and src_level may keep growing; the upstream side is responsible for its overflow.
- Empty region (occ == 0): reads are blocked.
- occ never exceeds DEPTH_BURSTS and never underflows, because increment and decrement cannot occur in the same cycle.
- Dropping enable mid-burst has no effect; the burst runs to completion.

## Timing
- Reset values:
  - All strobes and requests 0: wr_req, rd_req, src_rd, snk_wr.
  - snk_data = 0.
  - waddr = raddr = BASE_ADDR.
  - occ = 0, busy = 0, FSM in IDLE.
  - Arbitration history = "last served read", so writes win the first tie.
- IDLE to wr_req/rd_req high: 1 cycle (registered).
- src_rd is high for exactly BURST_LEN consecutive cycles, the first being the wr_ack cycle. wdata is combinational from src_data.
- snk_wr pulses lag rdata_vld by 1 cycle, exactly BURST_LEN per read burst.
- End of burst to IDLE decision: 1 cycle. Minimum gap between bursts is 2 cycles plus controller latency.
- A controller refresh delaying the ack simply extends REQ; the request stays asserted.
- Reset asserted mid-burst returns everything to reset values immediately. Stored SDRAM data is considered lost because occ = 0.

## Configuration
- SDRAM_SCHED_RR_EN defined: on a tie, round-robin; the direction not served last wins, and the history is updated at every burst start.
- SDRAM_SCHED_RR_EN undefined: on a tie, fixed priority, write always wins; no history register.

## Test plan
- Reset, src_level=300, snk_free=0, controller model acks after 5 cycles:
  - one WR burst at waddr=0.
  - src_rd high exactly 256 cycles.
  - occ=1; waddr becomes 256.
- occ=1, snk_free=512, src_level=0:
  - rd_req at raddr=0.
  - 256 rdata_vld beats give 256 snk_wr pulses, each 1 cycle later with matching data.
  - occ=0; raddr=256.
- DEPTH_BURSTS=2, continuous writes with no reads:
  - two bursts at 0 and 256, then occ=2 and wr_req stays 0.
  - one read frees a slot; the next write wraps to waddr=0.
- Both ready with RR_EN: alternating W,R,W,R bursts. Without RR_EN: writes every burst while src_level>=256.
- Assert rst_n low during WR_DATA beat 100: all outputs at reset values the same cycle, occ=0, waddr=0. After release, a new burst restarts at address 0.

Source files
------------

// File: rtl/sdram_burst_sched.sv
// Burst scheduler that treats an SDRAM region as a circular FIFO of BURST_LEN-word bursts.
// Optional macro SDRAM_SCHED_RR_EN: round-robin on a read/write tie; otherwise writes win ties.
module sdram_burst_sched #(
    parameter int          BURST_LEN    = 256,
    parameter logic [21:0] BASE_ADDR    = 22'd0,
    parameter int          DEPTH_BURSTS = 16384
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [9:0]  src_level,
    output logic        src_rd,
    input  logic [15:0] src_data,
    input  logic [9:0]  snk_free,
    output logic        snk_wr,
    output logic [15:0] snk_data,
    output logic        wr_req,
    output logic [21:0] waddr,
    output logic [15:0] wdata,
    input  logic        wr_ack,
    output logic        rd_req,
    output logic [21:0] raddr,
    input  logic        rd_ack,
    input  logic [15:0] rdata,
    input  logic        rdata_vld,
    output logic [14:0] occ,
    output logic        busy
);
    localparam int               CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [21:0]      STEP      = 22'(BURST_LEN);
    localparam logic [21:0]      LAST_ADDR = BASE_ADDR + 22'((DEPTH_BURSTS - 1) * BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
    localparam logic [14:0]      DEPTH_OCC = 15'(DEPTH_BURSTS);
    localparam logic [9:0]       BURST_LVL = 10'(BURST_LEN);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA} state_t;

    state_t           state_q;
    logic             wr_req_q;
    logic             rd_req_q;
    logic             snk_wr_q;
    logic [15:0]      snk_data_q;
    logic [21:0]      waddr_q;
    logic [21:0]      raddr_q;
    logic [21:0]      waddr_d;
    logic [21:0]      raddr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [14:0]      occ_q;
    logic             wr_ready;
    logic             rd_ready;
    logic             pick_wr;
    logic             pick_rd;
    logic             rd_phase;

    assign wr_ready = enable && (src_level >= BURST_LVL) && (occ_q < DEPTH_OCC);
    assign rd_ready = enable && (snk_free >= BURST_LVL) && (occ_q != 15'd0);
    assign rd_phase = (state_q == RD_REQ) || (state_q == RD_DATA);

    // Addresses step by one page and wrap back to the region base after the last slot.
    assign waddr_d = (waddr_q == LAST_ADDR) ? BASE_ADDR : waddr_q + STEP;
    assign raddr_d = (raddr_q == LAST_ADDR) ? BASE_ADDR : raddr_q + STEP;

`ifdef SDRAM_SCHED_RR_EN
    logic last_rd_q;

    assign pick_wr = wr_ready && (!rd_ready || last_rd_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_q <= 1'b1;
        end else if (state_q == IDLE && (wr_ready || rd_ready)) begin
            last_rd_q <= !pick_wr;
        end
    end
`else
    assign pick_wr = wr_ready;
`endif

    assign pick_rd = rd_ready && !pick_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_req_q   <= 1'b0;
            rd_req_q   <= 1'b0;
            snk_wr_q   <= 1'b0;
            snk_data_q <= 16'd0;
            waddr_q    <= BASE_ADDR;
            raddr_q    <= BASE_ADDR;
            cnt_q      <= '0;
            occ_q      <= 15'd0;
        end else begin
            // Read data outside a read burst is stale controller output and is dropped.
            snk_wr_q <= rdata_vld && rd_phase;
            if (rdata_vld && rd_phase) begin
                snk_data_q <= rdata;
            end

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pick_wr) begin
                        state_q  <= WR_REQ;
                        wr_req_q <= 1'b1;
                    end else if (pick_rd) begin
                        state_q  <= RD_REQ;
                        rd_req_q <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (wr_ack) begin
                        wr_req_q <= 1'b0;
                        cnt_q    <= CNT_W'(1);
                        state_q  <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (cnt_q == LAST_BEAT) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        occ_q   <= occ_q + 15'd1;
                        waddr_q <= waddr_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (rdata_vld) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (rd_ack) begin
                        rd_req_q <= 1'b0;
                        state_q  <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rdata_vld) begin
                        if (cnt_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            occ_q   <= occ_q - 15'd1;
                            raddr_q <= raddr_d;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The first source beat is consumed on the ack cycle itself, so src_rd looks at wr_ack directly.
    assign src_rd   = ((state_q == WR_REQ) && wr_ack) || (state_q == WR_DATA);
    assign wdata    = src_data;
    assign wr_req   = wr_req_q;
    assign rd_req   = rd_req_q;
    assign waddr    = waddr_q;
    assign raddr    = raddr_q;
    assign snk_wr   = snk_wr_q;
    assign snk_data = snk_data_q;
    assign occ      = occ_q;
    assign busy     = (state_q != IDLE);

endmodule
